// File: rtl/dna_port_emu.sv
// -----------------------------------------------------------------------------
// dna_port_emu
//   Behavioural responder for the 7-series DNA_PORT serial interface. A read
//   loads the device ID into a 57-bit shift register. Each shift then presents
//   the ID MSB first on dout while din fills the register from the LSB side.
//
//   Optional feature macro: DNA_EMU_WR_EN
//     When this macro is defined, the ID can be written once, before the first
//     read, through a wr_valid/wr_ready handshake.
//     When it is undefined, the ID is the constant DNA_VALUE.
// -----------------------------------------------------------------------------
module dna_port_emu #(
  parameter int               DNA_W     = 57,
  parameter logic [DNA_W-1:0] DNA_VALUE = 57'h123456789ABCDEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             read,
  input  logic             shift,
  input  logic             din,
  output logic             dout,
  output logic [6:0]       shift_cnt,
  output logic             exhausted,
  output logic             loaded
`ifdef DNA_EMU_WR_EN
  ,
  input  logic             wr_valid,
  input  logic [DNA_W-1:0] wr_data,
  output logic             wr_ready
`endif
);

  // The state name mirrors the loaded/shift_cnt encoding. It keeps the
  // transitions readable without adding any decode logic on the outputs.
  typedef enum logic [1:0] {
    IDLE,
    LOADED,
    SHIFTING,
    EXHAUSTED
  } state_t;

  localparam logic [6:0] LAST_CNT = 7'(DNA_W);

  state_t           state;
  logic [DNA_W-1:0] sr;
  logic [DNA_W-1:0] id_reg;

`ifdef DNA_EMU_WR_EN
  // The ID is programmable only until the first read. A read in the same cycle
  // takes priority: it loads the old ID, and the write is not accepted.
  assign wr_ready = !loaded && !read;

  // Capture an accepted write. It takes effect at the next read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_reg <= DNA_VALUE;
    end else if (wr_valid && wr_ready) begin
      id_reg <= wr_data;
    end
  end
`else
  assign id_reg = DNA_VALUE;
`endif

  // The MSB of the shift register is the serial output at all times.
  assign dout = sr[DNA_W-1];

  // Reader-facing FSM: a read (re)loads the ID, and a shift walks it out.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples pre-edge values, whatever order the statements are in.
    if (rst) begin
      state     <= IDLE;
      sr        <= '0;
      shift_cnt <= '0;
      exhausted <= 1'b0;
      loaded    <= 1'b0;
    end else if (read) begin
      // A read overrides any shift in the same cycle.
      state     <= LOADED;
      sr        <= id_reg;
      shift_cnt <= '0;
      exhausted <= 1'b0;
      loaded    <= 1'b1;
    end else if (shift) begin
      // The register shifts in every state. Only the counter depends on state.
      sr <= {sr[DNA_W-2:0], din};
      unique case (state)
        IDLE: begin
          // Shifts before the first read are not counted.
        end
        LOADED: begin
          state     <= SHIFTING;
          shift_cnt <= 7'd1;
        end
        SHIFTING: begin
          shift_cnt <= shift_cnt + 7'd1;
          if (shift_cnt == LAST_CNT - 7'd1) begin
            state     <= EXHAUSTED;
            exhausted <= 1'b1;
          end
        end
        EXHAUSTED: begin
          // The counter holds at its saturation value.
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dna_port_emu.sv
// -----------------------------------------------------------------------------
// tb_dna_port_emu
//   Directed bench for dna_port_emu. The stimulus process pushes the expected
//   post-edge outputs into a scoreboard queue. A monitor pops each entry on the
//   following falling edge and compares it against the DUT.
//   The optional write-port scenario runs only when DNA_EMU_WR_EN is defined.
// -----------------------------------------------------------------------------
module tb_dna_port_emu;

  localparam logic [56:0] ID_DEF = 57'h123456789ABCDEF;
  localparam logic [56:0] ID_WR  = 57'h0AA55AA55AA55AA;

  logic        clk;
  logic        rst;
  logic        read;
  logic        shift;
  logic        din;
  logic        dout;
  logic [6:0]  shift_cnt;
  logic        exhausted;
  logic        loaded;
`ifdef DNA_EMU_WR_EN
  logic        wr_valid;
  logic [56:0] wr_data;
  logic        wr_ready;
`endif

  dna_port_emu dut (
    .clk       (clk),
    .rst       (rst),
    .read      (read),
    .shift     (shift),
    .din       (din),
    .dout      (dout),
    .shift_cnt (shift_cnt),
    .exhausted (exhausted),
    .loaded    (loaded)
`ifdef DNA_EMU_WR_EN
    ,
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        dout;
    logic [6:0]  cnt;
    logic        exh;
    logic        ld;
    logic        wrr;
    bit          cap;
    bit          chk_word;
    logic [56:0] word;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [56:0] cap_word = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: compare every pending expectation on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.chk_word) check({e.name, ".word"}, 64'(cap_word), 64'(e.word));
        if (e.cap) cap_word = {cap_word[55:0], dout};
        check({e.name, ".dout"},      64'(dout),      64'(e.dout));
        check({e.name, ".shift_cnt"}, 64'(shift_cnt), 64'(e.cnt));
        check({e.name, ".exhausted"}, 64'(exhausted), 64'(e.exh));
        check({e.name, ".loaded"},    64'(loaded),    64'(e.ld));
`ifdef DNA_EMU_WR_EN
        check({e.name, ".wr_ready"},  64'(wr_ready),  64'(e.wrr));
`endif
      end
    end
  end

  task automatic push(input string nm, input logic e_dout, input int e_cnt,
                      input logic e_exh, input logic e_ld, input bit cap,
                      input bit chk_word, input logic [56:0] word);
    exp_t e;
    e.name = nm; e.dout = e_dout; e.cnt = 7'(e_cnt); e.exh = e_exh; e.ld = e_ld;
    e.wrr = !e_ld; e.cap = cap; e.chk_word = chk_word; e.word = word;
    sb.push_back(e);
  endtask

  // Apply one cycle of inputs and queue the outputs expected after the edge.
  // The inputs return to idle before the monitor samples the outputs.
  task automatic cyc(input string nm, input logic r, input logic s, input logic d,
                     input logic e_dout, input int e_cnt, input logic e_exh,
                     input logic e_ld, input bit cap = 0, input bit chk_word = 0,
                     input logic [56:0] word = '0);
    read = r; shift = s; din = d;
    @(posedge clk);
    push(nm, e_dout, e_cnt, e_exh, e_ld, cap, chk_word, word);
    #1;
    read = 1'b0; shift = 1'b0; din = 1'b0;
`ifdef DNA_EMU_WR_EN
    wr_valid = 1'b0; wr_data = '0;
`endif
    @(negedge clk);
    #1;
  endtask

  // Read once, then shift 57 zeros. dout is captured before each shift, so
  // the captured word must equal the loaded ID.
  task automatic read_and_capture(input string tag, input logic [56:0] id);
    cyc({tag, ".read"}, 1, 0, 0, id[56], 0, 0, 1, 1);
    for (int k = 1; k <= 56; k++)
      cyc($sformatf("%s.shift%0d", tag, k), 0, 1, 0, id[56-k], k, 0, 1, 1);
    cyc({tag, ".shift57"}, 0, 1, 0, 1'b0, 57, 1, 1, 0, 1, id);
  endtask

  task automatic rst_pulse(input string nm);
    @(posedge clk);
    #1 rst = 1'b1;
    push(nm, 0, 0, 0, 0, 0, 0, '0);
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; read = 1'b0; shift = 1'b0; din = 1'b0;
`ifdef DNA_EMU_WR_EN
    wr_valid = 1'b0; wr_data = '0;
`endif
    push("reset", 0, 0, 0, 0, 0, 0, '0);
    @(negedge clk);
    #1 rst = 1'b0;

    // Shifts before any read move sr but leave the counter and flags idle.
    for (int k = 1; k <= 10; k++)
      cyc($sformatf("preread.shift%0d", k), 0, 1, 1, 0, 0, 0, 0);

    // Full read-out of the default ID.
    read_and_capture("id_default", ID_DEF);

    // Extra shifts of 1s: the counter saturates. The zeros already in sr drain
    // out first, so dout turns to 1 only on the 57th extra shift.
    for (int j = 1; j <= 70; j++)
      cyc($sformatf("extra.shift%0d", j), 0, 1, 1, (j >= 57), 57, 1, 1);

    // A read and a shift in the same cycle: the load wins.
    cyc("read_and_shift", 1, 1, 1, 1, 0, 0, 1);
    cyc("repeat_read", 1, 0, 0, 1, 0, 0, 1);

    // Asynchronous reset in the middle of a read-out.
    cyc("midrst.read", 1, 0, 0, ID_DEF[56], 0, 0, 1);
    for (int k = 1; k <= 20; k++)
      cyc($sformatf("midrst.shift%0d", k), 0, 1, 0, ID_DEF[56-k], k, 0, 1);
    rst_pulse("midrst.in_reset");
    cyc("midrst.idle", 0, 0, 0, 0, 0, 0, 0);
    read_and_capture("after_rst", ID_DEF);

`ifdef DNA_EMU_WR_EN
    // One-time programming of the ID before the first read.
    rst_pulse("wr.reset");
    wr_valid = 1'b1; wr_data = ID_WR;
    cyc("wr.write", 0, 0, 0, 0, 0, 0, 0);
    read_and_capture("wr.first", ID_WR);
    // After a read, wr_ready is low, so this write of 0 must be ignored.
    wr_valid = 1'b1; wr_data = '0;
    cyc("wr.late_write", 0, 0, 0, 0, 57, 1, 1);
    read_and_capture("wr.second", ID_WR);
`endif

    // Let the monitor drain the queue, within a bounded number of cycles.
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    #1;
    check("scoreboard_drain", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
